// File: rtl/mips_pkg.sv
// Shared MIPS-subset constants: opcodes, ALU operation codes and the fetch FSM encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection from decoder controls and ALU zero; purely combinational, no handshake.
// Jump beats a taken branch; all arithmetic wraps modulo 2^32.
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        not_eq,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] w_pc4;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_br_off;
    logic        w_br_taken;
    logic        w_unused_opcode;

    assign w_pc4      = pc + 32'd4;
    assign w_jump_tgt = {w_pc4[31:28], instr[25:0], 2'b00};
    assign w_br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_br_taken = branch & (zero ^ not_eq);

    // The opcode field is decoded upstream; only the immediate/index fields matter here.
    assign w_unused_opcode = &{1'b0, instr[31:26]};

    always_comb begin
        next_pc = w_pc4;
        if (jump) begin
            next_pc = w_jump_tgt;
        end else if (w_br_taken) begin
            next_pc = w_pc4 + w_br_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: request until ack (>=1 cycle), hold instr until commit.
// Memory backpressure stalls FETCH indefinitely; decode backpressure (no commit) stalls ISSUE.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    input  logic             commit,
    input  logic             branch,
    input  logic             not_eq,
    input  logic             jump,
    input  logic             zero,
    output logic [CNT_W-1:0] retired
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      w_next_pc;
    logic             w_load_instr;
    logic             w_retire;

    next_pc_calc u_next_pc (
        .pc      (r_pc),
        .instr   (r_instr),
        .branch  (branch),
        .not_eq  (not_eq),
        .jump    (jump),
        .zero    (zero),
        .next_pc (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stray ack in ISSUE and stray commit in FETCH fall through as no-ops.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_instr = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            FETCH: begin
                if (imem_ack) begin
                    w_state_nxt  = ISSUE;
                    w_load_instr = 1'b1;
                end
            end
            ISSUE: begin
                if (commit) begin
                    w_state_nxt = FETCH;
                    w_retire    = 1'b1;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= PC_INIT;
            r_instr   <= 32'h0;
            r_retired <= '0;
        end else begin
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign imem_req    = (r_state == FETCH) & ~reset;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ISSUE);
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against an arithmetic next-PC reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0042;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        commit;
    logic        branch;
    logic        not_eq;
    logic        jump;
    logic        zero;
    logic [31:0] retired;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .commit      (commit),
        .branch      (branch),
        .not_eq      (not_eq),
        .jump        (jump),
        .zero        (zero),
        .retired     (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: word-address arithmetic straight from the ISA rules.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic b, input logic ne,
                                               input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (j)
            return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        else if (b && (z != ne))
            return seq + 32'(off);
        return seq;
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h0, imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Entered in FETCH with inputs idle; returns right after the commit edge.
    task automatic run_instr(input logic [31:0] w, input int lat, input int hold,
                             input logic b, input logic ne, input logic j, input logic z,
                             input bit stray);
        logic [31:0] exp_pc;
        chk("fetch_req", {31'h0, imem_req}, 32'h1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_valid", {31'h0, instr_valid}, 32'h0);
        for (int k = 1; k < lat; k++) begin
            commit = stray;
            jump   = 1'b1;
            @(negedge clk);
            commit = 1'b0;
            chk("addr_hold", imem_addr, m_pc);
            chk("pc_fetch", pc, m_pc);
            chk("ret_fetch", retired, m_ret);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("issue_valid", {31'h0, instr_valid}, 32'h1);
        chk("issue_instr", instr, w);
        chk("issue_req", {31'h0, imem_req}, 32'h0);
        for (int k = 0; k < hold; k++) begin
            imem_ack   = stray;
            imem_rdata = ~w;
            @(negedge clk);
            imem_ack = 1'b0;
            chk("issue_hold_instr", instr, w);
            chk("issue_hold_pc", pc, m_pc);
            chk("issue_hold_valid", {31'h0, instr_valid}, 32'h1);
        end
        commit = 1'b1;
        branch = b;
        not_eq = ne;
        jump   = j;
        zero   = z;
        exp_pc = model_next(m_pc, w, b, ne, j, z);
        @(negedge clk);
        commit = 1'b0;
        branch = 1'($urandom);
        not_eq = 1'($urandom);
        jump   = 1'($urandom);
        zero   = 1'($urandom);
        m_pc   = exp_pc;
        m_ret  = m_ret + 32'd1;
        chk("commit_pc", pc, m_pc);
        chk("commit_retired", retired, m_ret);
        chk("commit_valid", {31'h0, instr_valid}, 32'h0);
        chk("commit_req", {31'h0, imem_req}, 32'h1);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; commit = 1'b0;
        branch = 1'b0; not_eq = 1'b0; jump = 1'b0; zero = 1'b0;
        m_pc  = RST_PC & ~32'h3;
        m_ret = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", pc, 32'h0000_0040);
        chk("rst_retired", retired, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0000_0040);

        run_instr(32'h012A_4020, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("seq_0x44", pc, 32'h0000_0044);
        run_instr(mk_j(mips_pkg::OP_J, 26'h40), 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("j_0x100", pc, 32'h0000_0100);
        run_instr(mk_i(mips_pkg::OP_BEQ, 16'hFFFF), 2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("beq_taken", pc, 32'h0000_0100);
        run_instr(mk_i(mips_pkg::OP_BNE, 16'hFFFF), 1, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("bne_not_taken", pc, 32'h0000_0104);
        run_instr(mk_j(mips_pkg::OP_J, 26'h40), 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr(mk_i(mips_pkg::OP_BNE, 16'hFFFF), 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bne_taken", pc, 32'h0000_0100);
        run_instr(mk_j(mips_pkg::OP_J, 26'h0), 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("j_zero", pc, 32'h0000_0000);
        run_instr(mk_i(mips_pkg::OP_BEQ, 16'hFFFE), 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("beq_wrap_back", pc, 32'hFFFF_FFFC);
        run_instr(32'h0000_0000, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pc4_wrap", pc, 32'h0000_0000);
        run_instr(mk_j(mips_pkg::OP_J, 26'h3FF_FFFF), 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("j_max", pc, 32'h0FFF_FFFC);
        run_instr(mk_i(mips_pkg::OP_ADDI, 16'h1234), 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("seq_region", pc, 32'h1000_0000);
        run_instr(mk_j(mips_pkg::OP_J, 26'h10), 1, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("j_over_branch", pc, 32'h1000_0040);
        chk("retired_directed", retired, 32'd12);

        for (int n = 0; n < 40; n++) begin
            run_instr($urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pre_rst_valid", {31'h0, instr_valid}, 32'h1);
        reset      = 1'b1;
        commit     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        commit = 1'b0;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        m_pc  = RST_PC & ~32'h3;
        m_ret = 32'h0;
        chk("rst_issue_pc", pc, 32'h0000_0040);
        chk("rst_issue_retired", retired, 32'h0);
        chk("rst_issue_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_issue_instr", instr, 32'h0);
        chk("rst_issue_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        run_instr(mk_i(mips_pkg::OP_LW, 16'h0008), 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_seq", pc, 32'h0000_0044);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
